mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/riscv_pkg.sv | 18 +
 rtl/arb_timer.sv | 31 +++
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int STARVE_MAX_DEF = 4;
    localparam int TIMEOUT_DEF    = 255;

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

endpackage

// File: rtl/arb_timer.sv
// Counts granted cycles without a memory ack; flags the cycle that
// would be the TIMEOUT-th such cycle.
module arb_timer
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_expired = i_en && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory port, with
// fetch starvation guard and per-transaction timeout.
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_be,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              stall,
    output logic              err
);

    arb_state_t        r_state;
    logic [2:0]        r_starve;
    logic              r_m_req;
    logic              r_m_we;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_wdata;
    logic [3:0]        r_m_be;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_i_ready;
    logic              r_d_ready;
    logic              r_err;

    logic w_busy;
    logic w_starved;
    logic w_gnt_d;
    logic w_gnt_i;
    logic w_ack;
    logic w_tmo_en;
    logic w_tmo;
    logic w_done;
    logic w_done_i;
    logic w_done_d;

    assign w_busy    = (r_state == GNT_I) || (r_state == GNT_D);
    assign w_starved = i_req && (r_starve == 3'(STARVE_MAX));
    assign w_gnt_d   = (r_state == IDLE) && d_req && !w_starved;
    assign w_gnt_i   = (r_state == IDLE) && i_req && !w_gnt_d;
    assign w_ack     = w_busy && m_ack;
    assign w_tmo_en  = w_busy && !m_ack;
    assign w_done    = w_ack || w_tmo;
    assign w_done_i  = w_done && (r_state == GNT_I);
    assign w_done_d  = w_done && (r_state == GNT_D);

    arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .n_rst     (n_rst),
        .i_clr     (w_gnt_d || w_gnt_i),
        .i_en      (w_tmo_en),
        .o_expired (w_tmo)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= IDLE;
            r_starve <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_d) begin
                        r_state <= GNT_D;
                    end else if (w_gnt_i) begin
                        r_state <= GNT_I;
                    end
                    // fetch waiting only builds pressure while it keeps asking
                    if (w_gnt_i || !i_req) begin
                        r_starve <= '0;
                    end else if (w_gnt_d) begin
                        r_starve <= sat_inc3(r_starve);
                    end
                end
                GNT_I, GNT_D: begin
                    if (w_done) begin
                        r_state <= DONE;
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_m_be    <= '0;
        end else begin
            unique case (1'b1)
                w_gnt_d: begin
                    r_m_req   <= 1'b1;
                    r_m_we    <= d_we;
                    r_m_addr  <= d_addr;
                    r_m_wdata <= d_wdata;
                    r_m_be    <= d_be;
                end
                w_gnt_i: begin
                    r_m_req   <= 1'b1;
                    r_m_we    <= 1'b0;
                    r_m_addr  <= i_addr;
                    r_m_wdata <= '0;
                    r_m_be    <= 4'hF;
                end
                w_done: r_m_req <= 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_i_ready <= w_done_i;
            r_d_ready <= w_done_d;
            // an ack in the expiring cycle wins, so w_tmo implies no ack
            r_err     <= w_tmo;
            if (w_done_i) begin
                r_i_rdata <= w_ack ? m_rdata : '0;
            end
            if (w_done_d) begin
                r_d_rdata <= w_ack ? m_rdata : '0;
            end
        end
    end

    assign m_req   = r_m_req;
    assign m_we    = r_m_we;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign m_be    = r_m_be;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign i_ready = r_i_ready;
    assign d_ready = r_d_ready;
    assign err     = r_err;
    assign stall   = (i_req & ~i_ready) | (d_req & ~d_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant/completion scoreboards plus
// cycle-exact checks on latency, starvation, timeout and reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic [31:0] m_rdata;
    logic        m_ack = 1'b0;
    logic        stall;
    logic        err;

    int checks = 0;
    int errors = 0;
    int ack_lat = 0;
    int ack_cnt = 0;
    int hi;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        bit          chk_wd;
    } gnt_t;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        logic        e;
    } cpl_t;

    gnt_t gnt_q[$];
    cpl_t cpl_q[$];
    gnt_t g_m;
    cpl_t c_m;
    logic prev_mreq = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4),
        .TIMEOUT    (8)
    ) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ready (i_ready),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_be    (d_be),
        .d_rdata (d_rdata),
        .d_ready (d_ready),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_be    (m_be),
        .m_rdata (m_rdata),
        .m_ack   (m_ack),
        .stall   (stall),
        .err     (err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h1000_0000) return 32'h0000_0513;
        return a ^ 32'h5A5A_0000;
    endfunction

    assign m_rdata = mem_word(m_addr);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_g(input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          input bit cw);
        gnt_t g;
        g = '{we, a, wd, be, cw};
        gnt_q.push_back(g);
    endtask

    task automatic push_c(input bit is_d, input logic [31:0] data,
                          input logic e);
        cpl_t c;
        c = '{is_d, data, e};
        cpl_q.push_back(c);
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rdy(input bit is_d, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_d ? d_ready : i_ready) && n < 64);
        chk(tag, 32'(is_d ? d_ready : i_ready), 32'd1);
    endtask

    task automatic wait_mreq(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_req && n < 64);
        chk(tag, 32'(m_req), 32'd1);
    endtask

    // memory model: ack ack_lat cycles after m_req rises, -1 = never
    always @(negedge clk) begin
        if (m_req) begin
            m_ack   <= (ack_cnt == ack_lat);
            ack_cnt <= ack_cnt + 1;
        end else begin
            m_ack   <= 1'b0;
            ack_cnt <= 0;
        end
    end

    always @(negedge clk) begin
        if (m_req && !prev_mreq) begin
            if (gnt_q.size() == 0) begin
                chk("gnt_pending", 32'(gnt_q.size()), 32'd1);
            end else begin
                g_m = gnt_q.pop_front();
                chk("gnt_we", 32'(m_we), 32'(g_m.we));
                chk("gnt_addr", m_addr, g_m.addr);
                chk("gnt_be", 32'(m_be), 32'(g_m.be));
                if (g_m.chk_wd) chk("gnt_wdata", m_wdata, g_m.wdata);
            end
        end
        prev_mreq <= m_req;
    end

    always @(negedge clk) begin
        if (i_ready || d_ready) begin
            if (cpl_q.size() == 0) begin
                chk("cpl_pending", 32'(cpl_q.size()), 32'd1);
            end else begin
                c_m = cpl_q.pop_front();
                chk("cpl_d_ready", 32'(d_ready), 32'(c_m.is_d));
                chk("cpl_i_ready", 32'(i_ready), 32'(!c_m.is_d));
                chk("cpl_data", c_m.is_d ? d_rdata : i_rdata, c_m.data);
                chk("cpl_err", 32'(err), 32'(c_m.e));
            end
        end else if (err) begin
            chk("err_alone", 32'(err), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst   = 1'b0;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        d_be    = 4'hF;
        nclk(2);
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_m_we", 32'(m_we), 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_m_be", 32'(m_be), 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_i_ready", 32'(i_ready), 32'd0);
        chk("rst_d_ready", 32'(d_ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        n_rst = 1'b1;
        nclk(1);

        // single fetch, minimum latency
        i_req  = 1'b1;
        i_addr = 32'h1000_0000;
        push_g(1'b0, 32'h1000_0000, '0, 4'hF, 1'b0);
        push_c(1'b0, 32'h0000_0513, 1'b0);
        chk("a_c0_mreq", 32'(m_req), 32'd0);
        nclk(1);
        chk("a_c1_mreq", 32'(m_req), 32'd1);
        chk("a_c1_stall", 32'(stall), 32'd1);
        nclk(1);
        chk("a_c2_iready", 32'(i_ready), 32'd1);
        chk("a_c2_irdata", i_rdata, 32'h0000_0513);
        chk("a_c2_stall", 32'(stall), 32'd0);
        i_req = 1'b0;
        nclk(1);
        chk("a_c3_stall", 32'(stall), 32'd0);
        chk("a_c3_iready", 32'(i_ready), 32'd0);
        chk("a_c3_mreq", 32'(m_req), 32'd0);

        // simultaneous fetch and store: data first
        i_req   = 1'b1;
        i_addr  = 32'h2000_0000;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0010;
        d_wdata = 32'hCAFE_F00D;
        d_be    = 4'b0011;
        push_g(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'b0011, 1'b1);
        push_g(1'b0, 32'h2000_0000, '0, 4'hF, 1'b0);
        push_c(1'b1, mem_word(32'h0000_0010), 1'b0);
        push_c(1'b0, mem_word(32'h2000_0000), 1'b0);
        wait_rdy(1'b1, "b_d_ready");
        d_req = 1'b0;
        d_we  = 1'b0;
        d_be  = 4'hF;
        nclk(1);
        chk("b_idle_mreq", 32'(m_req), 32'd0);
        nclk(1);
        chk("b_i_mreq", 32'(m_req), 32'd1);
        chk("b_i_addr", m_addr, 32'h2000_0000);
        chk("b_i_we", 32'(m_we), 32'd0);
        wait_rdy(1'b0, "b_i_ready");
        i_req = 1'b0;

        // back-to-back loads starve a held fetch for four grants
        ack_lat = 2;
        i_req   = 1'b1;
        i_addr  = 32'h3000_0000;
        d_req   = 1'b1;
        d_addr  = 32'h0000_0100;
        for (int k = 0; k < 4; k++) begin
            push_g(1'b0, 32'h100 + 32'(4 * k), '0, 4'hF, 1'b0);
            push_c(1'b1, mem_word(32'h100 + 32'(4 * k)), 1'b0);
        end
        push_g(1'b0, 32'h3000_0000, '0, 4'hF, 1'b0);
        push_c(1'b0, mem_word(32'h3000_0000), 1'b0);
        push_g(1'b0, 32'h0000_0110, '0, 4'hF, 1'b0);
        push_c(1'b1, mem_word(32'h0000_0110), 1'b0);
        for (int k = 0; k < 4; k++) begin
            wait_rdy(1'b1, "c_d_ready");
            d_addr = 32'h100 + 32'(4 * (k + 1));
        end
        wait_rdy(1'b0, "c_i_ready");
        i_req = 1'b0;
        wait_rdy(1'b1, "c_d4_ready");
        d_req = 1'b0;

        // no ack: timeout after 8 granted cycles
        ack_lat = -1;
        d_req   = 1'b1;
        d_addr  = 32'h0000_0200;
        push_g(1'b0, 32'h0000_0200, '0, 4'hF, 1'b0);
        push_c(1'b1, 32'd0, 1'b1);
        wait_mreq("d_tmo_mreq");
        hi = 0;
        while (m_req && hi < 20) begin
            hi++;
            nclk(1);
        end
        chk("d_tmo_cycles", 32'(hi), 32'd8);
        chk("d_tmo_ready", 32'(d_ready), 32'd1);
        chk("d_tmo_err", 32'(err), 32'd1);
        chk("d_tmo_rdata", d_rdata, 32'd0);
        d_req = 1'b0;

        // ack in the expiring cycle completes normally
        ack_lat = 7;
        d_req   = 1'b1;
        d_addr  = 32'h0000_0204;
        push_g(1'b0, 32'h0000_0204, '0, 4'hF, 1'b0);
        push_c(1'b1, mem_word(32'h0000_0204), 1'b0);
        wait_mreq("d_late_mreq");
        hi = 0;
        while (m_req && hi < 20) begin
            hi++;
            nclk(1);
        end
        chk("d_late_cycles", 32'(hi), 32'd8);
        chk("d_late_ready", 32'(d_ready), 32'd1);
        chk("d_late_err", 32'(err), 32'd0);
        chk("d_late_rdata", d_rdata, mem_word(32'h0000_0204));
        d_req = 1'b0;

        // reset in the middle of a data grant
        ack_lat = -1;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0300;
        d_wdata = 32'h1234_5678;
        d_be    = 4'b1100;
        push_g(1'b1, 32'h0000_0300, 32'h1234_5678, 4'b1100, 1'b1);
        wait_mreq("e_mreq");
        nclk(2);
        chk("e_gnt_mreq", 32'(m_req), 32'd1);
        n_rst = 1'b0;
        #1;
        chk("e_rst_mreq", 32'(m_req), 32'd0);
        chk("e_rst_drdata", d_rdata, 32'd0);
        ack_lat = 0;
        i_req   = 1'b1;
        i_addr  = 32'h4000_0000;
        d_we    = 1'b0;
        d_addr  = 32'h0000_0304;
        d_be    = 4'hF;
        push_g(1'b0, 32'h0000_0304, '0, 4'hF, 1'b0);
        push_g(1'b0, 32'h4000_0000, '0, 4'hF, 1'b0);
        push_c(1'b1, mem_word(32'h0000_0304), 1'b0);
        push_c(1'b0, mem_word(32'h4000_0000), 1'b0);
        nclk(1);
        chk("e_rst_dready", 32'(d_ready), 32'd0);
        n_rst = 1'b1;
        nclk(1);
        chk("e_rel_dready", 32'(d_ready), 32'd0);
        chk("e_rel_mreq", 32'(m_req), 32'd1);
        chk("e_rel_addr", m_addr, 32'h0000_0304);
        wait_rdy(1'b1, "e_d_ready");
        d_req = 1'b0;
        wait_rdy(1'b0, "e_i_ready");
        i_req = 1'b0;
        nclk(2);

        chk("gnt_q_left", 32'(gnt_q.size()), 32'd0);
        chk("cpl_q_left", 32'(cpl_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
